// File: rtl/mc_pkg.sv
// Shared state, encoding and control-word definitions for the multicycle controller.
package mc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UNS = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Everything the datapath sees except ImmSrc/RegSrc, which follow Instr directly.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       reg_write;
    } ctrl_t;

    function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD:          return ALU_ADD;
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            CMD_EOR:          return ALU_EOR;
            CMD_MOV:          return ALU_MOV;
            default:          return ALU_ADD;
        endcase
    endfunction

    function automatic logic cmd_known(input logic [3:0] cmd);
        return cmd inside {CMD_ADD, CMD_SUB, CMD_CMP, CMD_AND, CMD_ORR, CMD_EOR, CMD_MOV};
    endfunction

    function automatic logic cmd_arith(input logic [3:0] cmd);
        return cmd inside {CMD_ADD, CMD_SUB, CMD_CMP};
    endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register and condition evaluator. Full ARM condition decoding is
// built only when COND_EXEC_EN is defined; otherwise every instruction executes.
module cond_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       nz_write,
    input  logic       cv_write,
    input  logic [3:0] alu_flags,
    input  logic [3:0] cond,
    output logic       cond_ex
);

    logic [3:0] flags;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else begin
            if (nz_write) flags[3:2] <= alu_flags[3:2];
            if (cv_write) flags[1:0] <= alu_flags[1:0];
        end
    end

`ifdef COND_EXEC_EN
    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = !z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = !c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = !n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = !v;
            4'b1000: cond_ex = c && !z;
            4'b1001: cond_ex = !c || z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = !z && (n == v);
            4'b1101: cond_ex = z || (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
`else
    logic unused_cond;

    assign cond_ex     = 1'b1;
    assign unused_cond = &{1'b0, cond, flags};
`endif

endmodule

// File: rtl/multicycle_controller.sv
// Micro-step sequencer for the shared-ALU multicycle datapath: one state per clock,
// registered control word. Condition evaluation depends on COND_EXEC_EN (see cond_unit).
module multicycle_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic        busy
);

    state_t     state;
    state_t     state_next;
    state_t     state_done;
    ctrl_t      ctrl;
    logic       cond_ex;
    logic [1:0] op;
    logic [3:0] cmd;
    logic       i_bit;
    logic       s_bit;
    logic       rd_pc;
    logic       in_exec;
    logic       flag_en;
    logic       nz_write;
    logic       cv_write;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign cmd          = Instr[24:21];
    assign i_bit        = Instr[25];
    assign s_bit        = Instr[20];
    assign rd_pc        = (Instr[15:12] == 4'hF);
    assign unused_instr = &{1'b0, Instr[19:16], Instr[11:0]};

    // Where an instruction goes when it is finished: keep running or park.
    assign state_done = start ? FETCH : IDLE;

    // Rejected commands leave the flags alone just as they leave the registers alone.
    assign in_exec  = (state == EXECR) || (state == EXECI);
    assign flag_en  = in_exec && cmd_known(cmd) && (s_bit || (cmd == CMD_CMP));
    assign nz_write = flag_en;
    assign cv_write = flag_en && cmd_arith(cmd);

    cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .nz_write  (nz_write),
        .cv_write  (cv_write),
        .alu_flags (ALUFlags),
        .cond      (Instr[31:28]),
        .cond_ex   (cond_ex)
    );

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = FETCH;
            FETCH:  state_next = DECODE;
            DECODE: begin
                if (!cond_ex) begin
                    state_next = state_done;
                end else begin
                    case (op)
                        OP_MEM: state_next = MEMADR;
                        OP_DP:  state_next = i_bit ? EXECI : EXECR;
                        OP_BR:  state_next = BRANCH;
                        OP_UNS: state_next = state_done;
                    endcase
                end
            end
            MEMADR: state_next = s_bit ? MEMRD : MEMWR;
            MEMRD:  state_next = MEMWB;
            EXECR, EXECI: state_next = (cmd == CMD_CMP) ? state_done : ALUWB;
            MEMWB, MEMWR, ALUWB, BRANCH: state_next = state_done;
            default: state_next = IDLE;
        endcase
    end

    // Control word for the state being entered; Instr is already held by then
    // except on entry to DECODE, whose word does not depend on it.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] c_cmd,
                                       input logic c_rd_pc);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.pc_write   = 1'b1;
            end
            DECODE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            MEMADR: c.alu_src_b = 2'b01;
            MEMRD:  c.adr_src   = 1'b1;
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.pc_write   = c_rd_pc;
            end
            MEMWR: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECR: c.alu_control = alu_decode(c_cmd);
            EXECI: begin
                c.alu_src_b   = 2'b01;
                c.alu_control = alu_decode(c_cmd);
            end
            ALUWB: begin
                c.reg_write = cmd_known(c_cmd);
                c.pc_write  = cmd_known(c_cmd) && c_rd_pc;
            end
            BRANCH: begin
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pc_write   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ctrl  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            ctrl  <= ctrl_for(state_next, cmd, rd_pc);
            busy  <= (state_next != IDLE);
        end
    end

    assign PCWrite    = ctrl.pc_write;
    assign AdrSrc     = ctrl.adr_src;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign ResultSrc  = ctrl.result_src;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUControl = ctrl.alu_control;
    assign RegWrite   = ctrl.reg_write;

    // Register-read and extender selects must track the live IR; forced low while parked.
    assign ImmSrc = busy ? op : 2'b00;
    assign RegSrc = busy ? {op == OP_MEM, op == OP_BR} : 2'b00;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller (both COND_EXEC_EN builds).
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] Instr = '0;
    logic [3:0]  ALUFlags = '0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, busy;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Packed view {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,RegWrite,busy}
    localparam logic [13:0] W_FETCH  = 14'b1_0_0_1_10_1_10_000_0_1;
    localparam logic [13:0] W_DECODE = 14'b0_0_0_0_10_1_10_000_0_1;
    localparam logic [13:0] W_EXECR  = 14'b0_0_0_0_00_0_00_000_0_1;
    localparam logic [13:0] W_ALUWB  = 14'b0_0_0_0_00_0_00_000_1_1;
    localparam logic [13:0] W_MEMADR = 14'b0_0_0_0_00_0_01_000_0_1;
    localparam logic [13:0] W_MEMRD  = 14'b0_1_0_0_00_0_00_000_0_1;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  flags;
        int          cycles;
        int          reg_w;
        int          mem_w;
        int          pc_w;
        int          adr;
        int          res_mem;
        logic [2:0]  alu;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    function automatic logic [13:0] outs();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, RegWrite, busy};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (busy && n < 12) begin
            step();
            n++;
        end
        check(name, 32'(busy), 32'h0);
    endtask

    // Runs one instruction from IDLE with a one-cycle start pulse and tallies the enables.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl,
                             output int cyc, output int rw, output int mw, output int pw,
                             output int adr, output int rm, output logic [2:0] alu_or);
        cyc = 0; rw = 0; mw = 0; pw = 0; adr = 0; rm = 0; alu_or = 3'b000;
        Instr = ins;
        ALUFlags = fl;
        start = 1'b1;
        step();
        start = 1'b0;
        while (busy && cyc < 16) begin
            cyc++;
            if (RegWrite) rw++;
            if (MemWrite) mw++;
            if (PCWrite) pw++;
            if (AdrSrc) adr++;
            if (ResultSrc == 2'b01) rm++;
            alu_or = alu_or | ALUControl;
            step();
        end
    endtask

    initial begin
        int cyc, rw, mw, pw, adr, rm;
        logic [2:0] alu;

        vecs[0]  = '{"ADD",    32'hE0821003, 4'h0, 4, 1, 0, 1, 0, 0, 3'b000};
        vecs[1]  = '{"SUBS",   32'hE0500000, 4'h4, 4, 1, 0, 1, 0, 0, 3'b001};
        vecs[2]  = '{"CMP",    32'hE3500000, 4'h0, 3, 0, 0, 1, 0, 0, 3'b001};
        vecs[3]  = '{"AND",    32'hE0012003, 4'h0, 4, 1, 0, 1, 0, 0, 3'b010};
        vecs[4]  = '{"ORR",    32'hE1812003, 4'h0, 4, 1, 0, 1, 0, 0, 3'b011};
        vecs[5]  = '{"EOR",    32'hE0212003, 4'h0, 4, 1, 0, 1, 0, 0, 3'b100};
        vecs[6]  = '{"MOVI",   32'hE3A01005, 4'h0, 4, 1, 0, 1, 0, 0, 3'b101};
        vecs[7]  = '{"TST",    32'hE1112003, 4'hF, 4, 0, 0, 1, 0, 0, 3'b000};
        vecs[8]  = '{"LDR",    32'hE5954008, 4'h0, 5, 1, 0, 1, 1, 1, 3'b000};
        vecs[9]  = '{"STR",    32'hE5854008, 4'h0, 4, 0, 1, 1, 1, 0, 3'b000};
        vecs[10] = '{"B",      32'hEA000002, 4'h0, 3, 0, 0, 2, 0, 0, 3'b000};
        vecs[11] = '{"ADDPC",  32'hE082F003, 4'h0, 4, 1, 0, 2, 0, 0, 3'b000};
        vecs[12] = '{"LDRPC",  32'hE595F008, 4'h0, 5, 1, 0, 2, 1, 1, 3'b000};
        vecs[13] = '{"OP11",   32'hEE000000, 4'h0, 2, 0, 0, 1, 0, 0, 3'b000};

        // Reset state
        step();
        step();
        check("reset outs", 32'(outs()), 32'h0);
        check("reset sel", 32'({ImmSrc, RegSrc}), 32'h0);
        reset = 1'b1;
        step();
        check("idle no start", 32'(outs()), 32'h0);

        // ADD with start held: full trace plus back-to-back refetch
        Instr = 32'hE0821003;
        start = 1'b1;
        step(); check("add fetch", 32'(outs()), 32'(W_FETCH));
        step(); check("add decode", 32'(outs()), 32'(W_DECODE));
        step(); check("add execr", 32'(outs()), 32'(W_EXECR));
        check("add immsrc", 32'(ImmSrc), 32'h0);
        step(); check("add aluwb", 32'(outs()), 32'(W_ALUWB));
        step(); check("add refetch", 32'(outs()), 32'(W_FETCH));
        start = 1'b0;
        drain("add drain");

        for (int i = 0; i < NVEC; i++) begin
            run_instr(vecs[i].instr, vecs[i].flags, cyc, rw, mw, pw, adr, rm, alu);
            check({vecs[i].name, " cycles"}, 32'(cyc), 32'(vecs[i].cycles));
            check({vecs[i].name, " regwrite"}, 32'(rw), 32'(vecs[i].reg_w));
            check({vecs[i].name, " memwrite"}, 32'(mw), 32'(vecs[i].mem_w));
            check({vecs[i].name, " pcwrite"}, 32'(pw), 32'(vecs[i].pc_w));
            check({vecs[i].name, " adrsrc"}, 32'(adr), 32'(vecs[i].adr));
            check({vecs[i].name, " result01"}, 32'(rm), 32'(vecs[i].res_mem));
            check({vecs[i].name, " alucontrol"}, 32'(alu), 32'(vecs[i].alu));
        end

        // Condition handling: SUBS sets Z, then BEQ / BNE / ADDNE / BEQ
        run_instr(32'hE0500000, 4'h4, cyc, rw, mw, pw, adr, rm, alu);
        check("subs cycles", 32'(cyc), 32'd4);
        run_instr(32'h0A000002, 4'h0, cyc, rw, mw, pw, adr, rm, alu);
        check("beq cycles", 32'(cyc), 32'd3);
        check("beq pcwrite", 32'(pw), 32'd2);
        run_instr(32'h1A000002, 4'h0, cyc, rw, mw, pw, adr, rm, alu);
`ifdef COND_EXEC_EN
        check("bne cycles", 32'(cyc), 32'd2);
        check("bne pcwrite", 32'(pw), 32'd1);
`else
        check("bne cycles", 32'(cyc), 32'd3);
        check("bne pcwrite", 32'(pw), 32'd2);
`endif
        run_instr(32'h10821003, 4'h0, cyc, rw, mw, pw, adr, rm, alu);
`ifdef COND_EXEC_EN
        check("addne cycles", 32'(cyc), 32'd2);
        check("addne regwrite", 32'(rw), 32'd0);
`else
        check("addne cycles", 32'(cyc), 32'd4);
        check("addne regwrite", 32'(rw), 32'd1);
`endif
        check("addne memwrite", 32'(mw), 32'd0);
        run_instr(32'h0A000002, 4'h0, cyc, rw, mw, pw, adr, rm, alu);
        check("beq again cycles", 32'(cyc), 32'd3);

        // LDR trace, reset dropped in MEMRD, then IDLE held until start
        Instr = 32'hE5954008;
        start = 1'b1;
        step(); check("ldr fetch", 32'(outs()), 32'(W_FETCH));
        start = 1'b0;
        step(); check("ldr decode", 32'(outs()), 32'(W_DECODE));
        step(); check("ldr memadr", 32'(outs()), 32'(W_MEMADR));
        check("ldr immsrc", 32'(ImmSrc), 32'h1);
        check("ldr regsrc", 32'(RegSrc), 32'h2);
        step(); check("ldr memrd", 32'(outs()), 32'(W_MEMRD));
        reset = 1'b0;
        #1;
        check("async reset outs", 32'(outs()), 32'h0);
        check("async reset sel", 32'({ImmSrc, RegSrc}), 32'h0);
        step();
        reset = 1'b1;
        step(); step(); step();
        check("post reset idle", 32'(outs()), 32'h0);
        start = 1'b1;
        step(); check("restart fetch", 32'(outs()), 32'(W_FETCH));
        start = 1'b0;
        drain("restart drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences the shared-ALU, shared-memory multicycle variant of the RSA CPU datapath. It decodes the latched instruction, holds the NZCV flag register and evaluates condition codes. It drives every datapath select and write enable, one micro-step per clock. It sits beside the datapath in the CPU top and replaces the single-cycle combinational decoder.

## Interface
Parameters: none.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; forces state IDLE, flags 0000, all outputs 0.
- `start` in 1: run enable; instruction fetch begins only when high.
- `Instr` in 32: instruction register contents from the datapath.
- `ALUFlags` in 4: NZCV from the ALU in the current cycle.
- `PCWrite` out 1: PC register load enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction register load enable.
- `ResultSrc` out 2: result select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 1: ALU A select; 0 = register A, 1 = PC.
- `ALUSrcB` out 2: ALU B select; 00 = WriteData, 01 = ExtImm, 10 = constant 4.
- `ALUControl` out 3: ALU operation code.
- `ImmSrc` out 2: immediate extender format; equals `Instr[27:26]`.
- `RegSrc` out 2: register-address selects, same meaning as the single-cycle decoder.
- `RegWrite` out 1: register file write enable.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- IDLE:
  - all enables 0;
  - goes to FETCH when `start`=1.
- FETCH:
  - drives `IRWrite`=1, `AdrSrc`=0, `ALUSrcA`=1, `ALUSrcB`=10, ADD, `ResultSrc`=10, `PCWrite`=1;
  - goes to DECODE.
- DECODE:
  - drives `ALUSrcA`=1, `ALUSrcB`=10, ADD, `ResultSrc`=10;
  - evaluates CondEx from `Instr[31:28]` against the stored flags.
  - CondEx=0 → FETCH (IDLE if `start`=0).
  - Otherwise branch on `Instr[27:26]`:
    - 01 → MEMADR;
    - 00 → EXECI if `Instr[25]`, else EXECR;
    - 10 → BRANCH;
    - 11 → FETCH (unsupported, treated as NOP).
- MEMADR:
  - drives `ALUSrcA`=0, `ALUSrcB`=01, ADD;
  - goes to MEMRD if `Instr[20]`, else MEMWR.
- MEMRD: drives `AdrSrc`=1; goes to MEMWB.
- MEMWB: drives `ResultSrc`=01, `RegWrite`=1. If Rd=15, also `PCWrite`=1.
- MEMWR: drives `AdrSrc`=1, `MemWrite`=1.
- EXECR / EXECI:
  - `ALUSrcA`=0; `ALUSrcB`=00 (EXECR) or 01 (EXECI);
  - decoded ALU op; flag update per the rules below;
  - goes to ALUWB, except CMP, which goes to FETCH.
- ALUWB: drives `ResultSrc`=00, `RegWrite`=1. If Rd=15, also `PCWrite`=1.
- BRANCH: drives `ALUSrcA`=0, `ALUSrcB`=01, ADD, `ResultSrc`=10, `PCWrite`=1.
- Return from terminal states: MEMWB, MEMWR, ALUWB, BRANCH and DECODE-skip go to FETCH if `start`=1, else IDLE.
- ALU decode, `Instr[24:21]` → `ALUControl`:
  - 0100 ADD → 000;
  - 0010 SUB → 001;
  - 1010 CMP → 001;
  - 0000 AND → 010;
  - 1100 ORR → 011;
  - 0001 EOR → 100;
  - 1101 MOV → 101;
  - any other cmd → 000, no writes.
- Flag update:
  - NZ loads from `ALUFlags[3:2]` in EXECR/EXECI when S (`Instr[20]`) or CMP.
  - CV loads from `ALUFlags[1:0]` under the same condition, but only for ADD/SUB/CMP.

## Timing
- All outputs are a Moore function of the state plus the held `Instr`. No output depends combinationally on `ALUFlags`.
- Cycles per instruction:
  - data-processing: 4;
  - CMP: 3;
  - LDR: 5;
  - STR: 4;
  - B: 3;
  - condition-failed or unsupported: 2.
- Flags written at the EXECR/EXECI clock edge are visible to the very next instruction's DECODE.
- `start` falling mid-instruction: the current instruction completes, then the FSM enters IDLE. No partial writes.
- `reset` low in any state: immediately IDLE, flags 0000, every enable 0, `busy`=0. No write occurs on that edge.

## Configuration
- `COND_EXEC_EN` defined:
  - full condition evaluation: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL;
  - cond 1111 evaluates false.
- `COND_EXEC_EN` undefined:
  - CondEx is hard-wired to 1 (every instruction executes);
  - the flag register still updates;
  - DECODE never skips.

## Structure
- Package `mc_pkg`:
  - `state_t` enum;
  - ALUControl code constants;
  - op (`Instr[27:26]`) constants;
  - cmd (`Instr[24:21]`) constants.
- Sub-module `cond_unit`: NZCV register plus the condition evaluator.
- FSM and output decode live in `multicycle_controller`.

## Test plan
- Reset, then `start`=1 with ADD R1,R2,R3 (0xE0821003): FETCH→DECODE→EXECR→ALUWB; `RegWrite`=1 only in ALUWB; `ALUControl`=000.
- SUBS R0,R0,R0 with `ALUFlags`=0100, then BEQ: branch takes BRANCH with `PCWrite`=1; with `COND_EXEC_EN` undefined and flags 0000, BNE also branches.
- LDR R4,[R5,#8] (0xE5954008): 5 cycles; `AdrSrc`=1 in MEMRD; `ResultSrc`=01 with `RegWrite` in MEMWB.
- STR (0xE5854008): `MemWrite`=1 exactly one cycle, in MEMWR; `RegWrite` never asserted.
- ADDNE with Z=1: DECODE→FETCH; no `RegWrite`, `MemWrite` or flag change.
- `reset` low asserted in MEMRD: outputs zero immediately; after release, IDLE held until `start`=1.
